// File: rtl/alu_ctrl_pkg.sv
// Shared types, opcode map and helpers for the ALU control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int OP_W = 16;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_NOTA = 4'd2;
  localparam logic [3:0] OPC_NAND = 4'd3;
  localparam logic [3:0] OPC_NOR  = 4'd4;
  localparam logic [3:0] OPC_AND  = 4'd5;
  localparam logic [3:0] OPC_OR   = 4'd6;
  localparam logic [3:0] OPC_XOR  = 4'd7;
  localparam logic [3:0] OPC_XNOR = 4'd8;
  localparam logic [3:0] OPC_LAST = OPC_XNOR;

  // Opcodes above XNOR have no ALU operation behind them.
  function automatic logic is_legal_opcode(input logic [3:0] opc);
    return (opc <= OPC_LAST);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and ALU-drive signals of the op sequencer, bundled for port hookup.
// Latency: n/a (wiring only).
// Backpressure: Start is only honoured while Busy is low; no queuing.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 16
);

  logic              Start;
  logic [3:0]        Opcode;
  logic [DATA_W-1:0] In_A;
  logic [DATA_W-1:0] In_B;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   OP;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, Opcode, In_A, In_B,
    input  A, B, OP, Busy, Done, Err
  );

  modport slave (
    input  Start, Opcode, In_A, In_B,
    output A, B, OP, Busy, Done, Err
  );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational 4-to-one-hot opcode decoder with a legality flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module alu_op_decoder #(
  parameter int OP_W = 16
) (
  input  logic [3:0]      opcode,
  output logic [OP_W-1:0] onehot,
  output logic            legal
);
  import alu_ctrl_pkg::*;

  // One bit per opcode; legality is reported separately so callers choose the illegal policy.
  always_comb begin
    onehot         = '0;
    onehot[opcode] = 1'b1;
  end

  assign legal = is_legal_opcode(opcode);

endmodule

// File: rtl/alu_op_sequencer.sv
// Captures an opcode/operand pair on Start, drives stable A/B and one-hot OP, waits out ALU latency, pulses Done.
// Latency: Start accepted at edge k -> A/B after k, OP after k+1, Done high k+2..k+3 (WAIT_CYCLES=1).
// Backpressure: Start ignored while Busy; illegal-opcode trap selected by CTRL_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic               Clk,
  input logic               Reset,
  alu_op_sequencer_if.slave bus
);
  import alu_ctrl_pkg::*;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("alu_op_sequencer: WAIT_CYCLES must be >= 1");
  end
  if (OP_W < 16) begin : g_bad_opw
    $error("alu_op_sequencer: OP_W must be >= 16");
  end

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic [3:0]        opc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   dec_onehot;
  logic              dec_legal;
  logic              load_ab;

  alu_op_decoder #(.OP_W(OP_W)) u_dec (
    .opcode (opc_q),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q;
  // A trapped opcode must leave the ALU operands untouched, so gate the operand load on legality.
  assign load_ab = accept && is_legal_opcode(bus.Opcode);
`else
  assign load_ab = accept;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          accept  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = dec_legal ? EXEC : DONE;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand/opcode capture, OP word update and wait counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      opc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        opc_q <= bus.Opcode;
      end
      if (load_ab) begin
        a_q <= bus.In_A;
        b_q <= bus.In_B;
      end
      if (state_q == DECODE) begin
        cnt_q <= CNT_W'(WAIT_CYCLES - 1);
        if (dec_legal) begin
          op_q <= dec_onehot;
        end else begin
`ifndef CTRL_ILLEGAL_TRAP_EN
          // OP=0 makes the ALU clear its result rather than compute garbage.
          op_q <= '0;
`endif
        end
      end
      if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared by the next accepted Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state_q == DECODE) && !dec_legal) begin
      err_q <= 1'b1;
    end
  end
  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.OP   = op_q;
  assign bus.Busy = (state_q != IDLE);
  assign bus.Done = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed transactions with a scoreboard of expected Done results.
// Latency: expected Done cycle is stored per transaction and compared on each Done pulse.
// Backpressure: exercises Start held high while Busy and reset mid-operation.
module tb_alu_op_sequencer;

  typedef struct {
    int         done_cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] op;
    logic       err;
  } exp_t;

  logic Clk;
  logic Reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   done_count;
  exp_t sb[$];

  alu_op_sequencer_if #(.DATA_W(8), .OP_W(16)) bus ();

  alu_op_sequencer #(
    .DATA_W      (8),
    .OP_W        (16),
    .WAIT_CYCLES (1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic start_op(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
    bus.Start  = 1'b1;
    bus.Opcode = opc;
    bus.In_A   = a;
    bus.In_B   = b;
  endtask

  task automatic push_exp(input int dc, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] op, input logic err);
    exp_t e;
    e.done_cyc = dc;
    e.a        = a;
    e.b        = b;
    e.op       = op;
    e.err      = err;
    sb.push_back(e);
  endtask

  // Scoreboard side: every Done pulse must match the oldest expected transaction.
  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("done_A", {24'd0, bus.A}, {24'd0, e.a});
        check("done_B", {24'd0, bus.B}, {24'd0, e.b});
        check("done_OP", {16'd0, bus.OP}, {16'd0, e.op});
        check("done_Err", {31'd0, bus.Err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    int base;
    int d0;
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    done_count = 0;

    // Reset held two cycles with a Start pending that must be ignored.
    Reset = 1'b1;
    start_op(4'd3, 8'h55, 8'hAA);
    step();
    step();
    check("rst_A", {24'd0, bus.A}, 32'd0);
    check("rst_B", {24'd0, bus.B}, 32'd0);
    check("rst_OP", {16'd0, bus.OP}, 32'd0);
    check("rst_Busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_Done", {31'd0, bus.Done}, 32'd0);
    check("rst_Err", {31'd0, bus.Err}, 32'd0);
    Reset     = 1'b0;
    bus.Start = 1'b0;
    step();
    check("idle_after_rst_Busy", {31'd0, bus.Busy}, 32'd0);

    // Basic ADD transaction.
    start_op(4'd0, 8'h25, 8'h13);
    push_exp(cyc + 3, 8'h25, 8'h13, 16'h0001, 1'b0);
    step();
    bus.Start = 1'b0;
    check("add_A", {24'd0, bus.A}, 32'h25);
    check("add_B", {24'd0, bus.B}, 32'h13);
    check("add_Busy", {31'd0, bus.Busy}, 32'd1);
    check("add_OP_not_yet", {16'd0, bus.OP}, 32'd0);
    step();
    check("add_OP", {16'd0, bus.OP}, 32'h0001);
    step();
    step();
    check("add_idle_Busy", {31'd0, bus.Busy}, 32'd0);
    check("add_idle_OP_held", {16'd0, bus.OP}, 32'h0001);
    check("add_idle_Done", {31'd0, bus.Done}, 32'd0);

    // Start held high for 12 cycles: accepts every 4 cycles only.
    base = cyc;
    d0   = done_count;
    start_op(4'd1, 8'h0A, 8'h05);
    push_exp(base + 3, 8'h0A, 8'h05, 16'h0002, 1'b0);
    push_exp(base + 7, 8'h0A, 8'h05, 16'h0002, 1'b0);
    push_exp(base + 11, 8'h0A, 8'h05, 16'h0002, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i >= 1) check("held_OP", {16'd0, bus.OP}, 32'h0002);
    end
    bus.Start = 1'b0;
    check("held_done_count", done_count - d0, 32'd3);
    step();
    check("held_idle_Busy", {31'd0, bus.Busy}, 32'd0);

    // Illegal opcode.
    start_op(4'hC, 8'h77, 8'h88);
`ifdef CTRL_ILLEGAL_TRAP_EN
    push_exp(cyc + 2, 8'h0A, 8'h05, 16'h0002, 1'b1);
`else
    push_exp(cyc + 3, 8'h77, 8'h88, 16'h0000, 1'b0);
`endif
    step();
    bus.Start = 1'b0;
    step();
    step();
    step();
    check("ill_Busy", {31'd0, bus.Busy}, 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_OP", {16'd0, bus.OP}, 32'h0002);
    check("ill_Err", {31'd0, bus.Err}, 32'd1);
`else
    check("ill_OP", {16'd0, bus.OP}, 32'h0000);
    check("ill_Err", {31'd0, bus.Err}, 32'd0);
`endif

    // Inputs wiggled while Busy must not disturb the captured values.
    start_op(4'd7, 8'h3C, 8'hC3);
    push_exp(cyc + 3, 8'h3C, 8'hC3, 16'h0080, 1'b0);
    step();
    bus.Start  = 1'b0;
    bus.In_A   = 8'hFF;
    bus.In_B   = 8'h00;
    bus.Opcode = 4'd2;
    check("busy_Err_cleared", {31'd0, bus.Err}, 32'd0);
    check("busy_A", {24'd0, bus.A}, 32'h3C);
    step();
    check("busy_A2", {24'd0, bus.A}, 32'h3C);
    check("busy_OP", {16'd0, bus.OP}, 32'h0080);
    step();
    step();
    check("busy_A_idle", {24'd0, bus.A}, 32'h3C);
    check("busy_idle_Busy", {31'd0, bus.Busy}, 32'd0);

    // Reset while in EXEC: no Done, everything cleared.
    start_op(4'd5, 8'hF0, 8'h0F);
    step();
    bus.Start = 1'b0;
    step();
    check("exec_OP", {16'd0, bus.OP}, 32'h0020);
    check("exec_Busy", {31'd0, bus.Busy}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_Busy", {31'd0, bus.Busy}, 32'd0);
    check("midrst_OP", {16'd0, bus.OP}, 32'd0);
    check("midrst_A", {24'd0, bus.A}, 32'd0);
    check("midrst_B", {24'd0, bus.B}, 32'd0);
    check("midrst_Done", {31'd0, bus.Done}, 32'd0);
    step();
    step();
    start_op(4'd6, 8'h11, 8'h22);
    push_exp(cyc + 3, 8'h11, 8'h22, 16'h0040, 1'b0);
    step();
    bus.Start = 1'b0;
    step();
    step();
    step();
    check("post_rst_Busy", {31'd0, bus.Busy}, 32'd0);
    check("post_rst_OP", {16'd0, bus.OP}, 32'h0040);

    step();
    step();
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
